// File: rtl/glb_read_sequencer.sv
// Streams a contiguous global-buffer region out of read port B onto the X bus, tagging words 1..kernel_size.
// Optional stall counter is built when GLB_SEQ_PERF_EN is defined.
module glb_read_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned NUM_COL    = 8
) (
  input  logic                       bus_clk,
  input  logic                       rst,
  input  logic                       cfg_start,
  input  logic [ADDR_WIDTH-1:0]      cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0]      cfg_num_words,
  input  logic [7:0]                 cfg_kernel_size,
  input  logic                       glb_rst_busy,
  output logic [ADDR_WIDTH-1:0]      glb_addrb,
  output logic                       glb_enb,
  input  logic [DATA_WIDTH-1:0]      glb_doutb,
  output logic                       bus_valid,
  input  logic                       bus_ready,
  output logic [DATA_WIDTH-1:0]      bus_data,
  output logic [$clog2(NUM_COL):0]   bus_x_id,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err,
  output logic [31:0]                perf_stall_cycles
);

  localparam int unsigned XW = $clog2(NUM_COL) + 1;
  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t          state;
  logic [AW-1:0]   base_q;
  logic [AW-1:0]   num_q;
  logic [AW-1:0]   issued_q;
  logic [AW-1:0]   addr_q;
  logic [7:0]      ks_q;
  logic [XW-1:0]   tag_q;
  logic [XW-1:0]   tag_pipe_q;
  logic            inflight_q;
  logic [DW-1:0]   fifo_data [2];
  logic [XW-1:0]   fifo_tag  [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count_q;

  logic            pop;
  logic [2:0]      occ;
  logic            credit;
  logic            issue;
  logic            cfg_bad;
  logic            accept;

  assign cfg_bad = (cfg_kernel_size == 8'd0) || (cfg_kernel_size > 8'(NUM_COL)) ||
                   (cfg_num_words == '0);
  assign accept  = (state == S_IDLE) && cfg_start && !glb_rst_busy && !cfg_bad;

  // Credit counts the word leaving this cycle so a steady stream runs at one word per cycle.
  assign pop    = bus_valid && bus_ready;
  assign occ    = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign credit = (occ < 3'd2);
  assign issue  = (state == S_STREAM) && credit && !glb_rst_busy;

  assign glb_enb   = issue;
  assign glb_addrb = issue ? AW'(base_q + issued_q) : addr_q;

  assign bus_valid = (count_q != 2'd0);
  assign bus_data  = fifo_data[rd_ptr];
  assign bus_x_id  = fifo_tag[rd_ptr];
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge bus_clk) begin
    if (rst) begin
      state        <= S_IDLE;
      base_q       <= '0;
      num_q        <= '0;
      issued_q     <= '0;
      addr_q       <= '0;
      ks_q         <= '0;
      tag_q        <= '0;
      tag_pipe_q   <= '0;
      inflight_q   <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_tag[0]  <= '0;
      fifo_tag[1]  <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count_q      <= 2'd0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_err    <= 1'b0;
      inflight_q <= issue;

      if (issue) begin
        addr_q     <= glb_addrb;
        issued_q   <= AW'(issued_q + AW'(1));
        tag_pipe_q <= tag_q;
        tag_q      <= (8'(tag_q) == ks_q) ? XW'(1) : XW'(tag_q + XW'(1));
      end

      // Read data lands one cycle after the enable, paired with its pipelined tag.
      if (inflight_q) begin
        fifo_data[wr_ptr] <= glb_doutb;
        fifo_tag[wr_ptr]  <= tag_pipe_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count_q <= count_q + 2'(inflight_q) - 2'(pop);

      case (state)
        S_IDLE: begin
          if (cfg_start && !glb_rst_busy) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              base_q   <= cfg_base_addr;
              num_q    <= cfg_num_words;
              ks_q     <= cfg_kernel_size;
              issued_q <= '0;
              tag_q    <= XW'(1);
              state    <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (issue && (AW'(issued_q + AW'(1)) == num_q)) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((count_q == 2'd0) && !inflight_q) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GLB_SEQ_PERF_EN
  // Saturating count of cycles a presented word is held off by the consumer.
  always_ff @(posedge bus_clk) begin
    if (rst) begin
      perf_stall_cycles <= 32'd0;
    end else if (accept) begin
      perf_stall_cycles <= 32'd0;
    end else if (bus_valid && !bus_ready && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`else
  assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: doc/glb_read_sequencer.md
Name: glb_read_sequencer

Overview:
- Controller that streams a contiguous ifmap region out of the global buffer's read port (port B) onto the X bus toward the PE array.
- Generates the read addresses and the read enable for the buffer.
- Tags each word with a PE column ID that cycles 1..kernel_size.
- Presents tagged words through a valid/ready handshake, with lossless backpressure across the buffer's 1-cycle read latency.

Parameters:
- DATA_WIDTH, 16, width of buffer words and bus data.
- ADDR_WIDTH, 16, width of buffer addresses and word counts.
- NUM_COL, 8, number of PE columns; maximum legal kernel_size.

Ports:
- bus_clk  input  1  single clock for all logic.
- rst  input  1  synchronous, active-high reset.
- cfg_start  input  1  start pulse; sampled only in IDLE.
- cfg_base_addr  input  ADDR_WIDTH  first buffer address to read.
- cfg_num_words  input  ADDR_WIDTH  number of words to stream.
- cfg_kernel_size  input  8  tag wrap value.
- glb_rst_busy  input  1  buffer reset in progress; blocks start and stalls reads.
- glb_addrb  output  ADDR_WIDTH  buffer read address.
- glb_enb  output  1  buffer read enable, one per issued read.
- glb_doutb  input  DATA_WIDTH  buffer read data, valid 1 cycle after glb_enb.
- bus_valid  output  1  tagged word available.
- bus_ready  input  1  consumer accepts the word when high together with bus_valid.
- bus_data  output  DATA_WIDTH  word payload.
- bus_x_id  output  $clog2(NUM_COL)+1  PE column tag, range 1..kernel_size.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the stream completes.
- cfg_err  output  1  one-cycle pulse when a start is rejected.
- perf_stall_cycles  output  32  backpressure counter (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0; FIFO and in-flight flag are cleared.
  - Applies in any state; a stream in progress is abandoned with no done pulse.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE, on cfg_start=1 and glb_rst_busy=0:
  - If cfg_kernel_size==0, cfg_kernel_size>NUM_COL or cfg_num_words==0: pulse cfg_err for 1 cycle and stay in IDLE.
  - Otherwise latch base address, word count and kernel size, and go to STREAM.
  - cfg_start together with glb_rst_busy=1 is ignored, with no error.
- cfg_start while busy is ignored.
- Output storage is a 2-entry FIFO of {data, tag}.
  - A read may issue only when fifo_count + inflight < 2, so the FIFO never overflows.
  - inflight is 1 in the cycle after glb_enb.
- STREAM read issue:
  - Condition: credit available and glb_rst_busy=0.
  - glb_enb=1 and glb_addrb=base+issued_count; address arithmetic wraps modulo 2^ADDR_WIDTH.
  - The tag is assigned at issue, starting at 1; after kernel_size it wraps to 1.
  - The tag is pipelined 1 cycle and written into the FIFO together with glb_doutb.
- glb_enb=0 and glb_addrb holds its last value whenever no read issues.
- After the final issue (issued_count == num_words): go to DRAIN.
- DRAIN → DONE when the FIFO is empty and inflight=0.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy is high in STREAM, DRAIN and DONE.
- bus_valid = FIFO not empty; bus_data and bus_x_id are the FIFO head.
  - Pop happens on bus_valid && bus_ready.
  - Simultaneous push and pop keeps the count unchanged.
  - bus_data and bus_x_id must stay stable while bus_valid=1 and bus_ready=0.
- Latency, with bus_ready held high: first bus_valid appears 2 cycles after the STREAM entry edge.
- Throughput: 1 word/cycle sustained.
- Words are delivered in address order; none are dropped or duplicated.

Optional Feature:
- Macro: GLB_SEQ_PERF_EN.
- Defined:
  - perf_stall_cycles increments every cycle with bus_valid=1 and bus_ready=0.
  - It saturates at 2^32-1.
  - It clears on an accepted start and on reset.
- Undefined: perf_stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Basic stream: base=0x0010, num_words=6, kernel_size=3, bus_ready=1 → bus_x_id 1,2,3,1,2,3 with data mem[0x10..0x15]; done pulses once; busy is low afterwards.
- Backpressure: same config, bus_ready toggles 1,0,0,1,… → all 6 words delivered in order; data and tag stable while stalled; glb_enb never issues with credit exhausted.
- Config errors: kernel_size=0, then kernel_size=NUM_COL+1, then num_words=0 → cfg_err pulses each time; busy stays 0; glb_enb stays 0.
- Boundaries: base=0xFFFE, num_words=4, kernel_size=NUM_COL → addresses 0xFFFE,0xFFFF,0x0000,0x0001; tags 1,2,3,4.
- Mid-operation disruption:
  - glb_rst_busy=1 for 3 cycles in STREAM → no glb_enb during those cycles; resume loses no words.
  - rst asserted mid-stream → all outputs 0 next cycle; no done pulse.
- Perf counter (GLB_SEQ_PERF_EN defined): 5 stalled cycles in one stream → perf_stall_cycles=5; next accepted start clears it to 0. Without the macro it reads 0.
